muldiv_seq: RTL and testbench

Iterative 32-cycle unsigned multiply/divide sequencer attached beside the EX stage ALU. It accepts an operation from the ID/EX register and holds the pipeline with a stall request while it iterates. It delivers a 64-bit result into HI/LO holding registers, which the EX stage reads in the completion cycle. One operation is in flight at a time. A pipeline flush aborts it.

---
 rtl/muldiv_seq.sv | 132 +++++++++++++
 tb/tb_muldiv_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer beside the EX-stage ALU.
// Shift-add MULU and restoring DIVU, one bit per cycle, result into HI/LO.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;      // MULU running product
  logic [2*XLEN-1:0]   mcand_q, mcand_d;  // MULU multiplicand, shifted left each iteration
  logic [XLEN-1:0]     b_q, b_d;          // MULU multiplier (shifted right) or DIVU divisor
  logic [XLEN-1:0]     quo_q, quo_d;      // DIVU dividend bits out at the top, quotient bits in at the bottom
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic [XLEN:0]       rem_shift;
  logic [XLEN:0]       rem_trial;

  // NOTE: every signal assigned here gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // The remainder stays below the divisor, so only the trial needs the extra sign bit.
    rem_shift = {rem_q, quo_q[XLEN-1]};
    rem_trial = rem_shift - {1'b0, b_q};

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = {{XLEN{1'b0}}, opa};
          b_d     = opb;
          quo_d   = opa;
          rem_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(XLEN)) begin
          state_d = S_DONE;
          hi_d    = op_q ? rem_q : acc_q[2*XLEN-1:XLEN];
          lo_d    = op_q ? quo_q : acc_q[XLEN-1:0];
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!op_q) begin
            if (b_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
          end else if (!rem_trial[XLEN]) begin
            rem_d = rem_trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Reset gates stall directly so a held start cannot freeze the pipe while rst_n is low.
  assign stall = rst_n && (((state_q == S_IDLE) && start && !flush) || (state_q == S_RUN));
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE) && !flush;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed and randomized MULU/DIVU
// operations compared against plain-arithmetic reference results.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .opa   (opa),
    .opb   (opb),
    .flush (flush),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference result as {hi, lo}: full product, or {remainder, quotient}.
  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    if (!o) begin
      p = longint'({32'b0, a}) * longint'({32'b0, b});
      return p;
    end
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Issue an operation from IDLE (called at posedge+1) and wait for done with a bound.
  // Returns the edges counted after the start edge and cycles where stall/busy were low.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int stall_lo, output int busy_lo);
    start = 1'b1; op = o; opa = a; opb = b; flush = 1'b0;
    stall_lo = 0; busy_lo = 0; cyc = 0;
    #1;
    if (!stall) stall_lo++;
    @(posedge clk); #1;
    while (!done && cyc < 40) begin
      if (!stall) stall_lo++;
      if (!busy) busy_lo++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; op = 1'b0; opa = 32'd5; opb = 32'd6; flush = 1'b0;
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_mis++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_mis++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_mis++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_hold_busy: got %b want 0", busy); end
    start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mulu();
    logic [31:0] va[5];
    logic [31:0] vb[5];
    logic [63:0] exp_r;
    int cyc, slo, blo;
    va[0] = 32'd7;          vb[0] = 32'd6;
    va[1] = 32'hFFFF_FFFF;  vb[1] = 32'hFFFF_FFFF;
    va[2] = 32'h0;          vb[2] = 32'h1234_5678;
    va[3] = $urandom;       vb[3] = $urandom;
    va[4] = $urandom;       vb[4] = $urandom_range(255, 0);
    for (int i = 0; i < 5; i++) begin
      exp_r = ref_result(1'b0, va[i], vb[i]);
      run_op(1'b0, va[i], vb[i], cyc, slo, blo);
      n_cmp++; if (cyc !== 33) begin n_mis++; $display("FAIL mulu_latency[%0d]: got %0d want 33", i, cyc); end
      n_cmp++; if (slo !== 0 || blo !== 0) begin n_mis++; $display("FAIL mulu_stall_busy[%0d]: stall low %0d busy low %0d want 0/0", i, slo, blo); end
      n_cmp++; if (hi !== exp_r[63:32]) begin n_mis++; $display("FAIL mulu_hi[%0d]: got %h want %h", i, hi, exp_r[63:32]); end
      n_cmp++; if (lo !== exp_r[31:0]) begin n_mis++; $display("FAIL mulu_lo[%0d]: got %h want %h", i, lo, exp_r[31:0]); end
      n_cmp++; if (stall !== 1'b0 || busy !== 1'b0) begin n_mis++; $display("FAIL mulu_done_stall[%0d]: stall %b busy %b want 0/0", i, stall, busy); end
      start = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL mulu_done_pulse[%0d]: got %b want 0", i, done); end
      last_hi = exp_r[63:32]; last_lo = exp_r[31:0];
    end
  endtask

  task automatic test_divu();
    logic [31:0] va[5];
    logic [31:0] vb[5];
    logic [63:0] exp_r;
    int cyc, slo, blo;
    va[0] = 32'h1234_5678;  vb[0] = 32'd0;
    va[1] = 32'hFFFF_FFFF;  vb[1] = 32'hFFFF_FFFF;
    va[2] = 32'd5;          vb[2] = 32'h8000_0000;
    va[3] = $urandom;       vb[3] = $urandom_range(1000, 1);
    va[4] = 32'd100;        vb[4] = 32'd7;
    for (int i = 0; i < 5; i++) begin
      exp_r = ref_result(1'b1, va[i], vb[i]);
      run_op(1'b1, va[i], vb[i], cyc, slo, blo);
      n_cmp++; if (cyc !== 33) begin n_mis++; $display("FAIL divu_latency[%0d]: got %0d want 33", i, cyc); end
      n_cmp++; if (slo !== 0 || blo !== 0) begin n_mis++; $display("FAIL divu_stall_busy[%0d]: stall low %0d busy low %0d want 0/0", i, slo, blo); end
      n_cmp++; if (hi !== exp_r[63:32]) begin n_mis++; $display("FAIL divu_rem[%0d]: got %h want %h", i, hi, exp_r[63:32]); end
      n_cmp++; if (lo !== exp_r[31:0]) begin n_mis++; $display("FAIL divu_quo[%0d]: got %h want %h", i, lo, exp_r[31:0]); end
      start = 1'b0;
      @(posedge clk); #1;
      last_hi = exp_r[63:32]; last_lo = exp_r[31:0];
    end
  endtask

  task automatic test_flush();
    logic [63:0] exp_r;
    int n_done;
    // Flush during RUN: no result, HI/LO keep the previous values.
    start = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd5; flush = 1'b0;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1 || done !== 1'b0) begin n_mis++; $display("FAIL flush_run_outputs: stall %b done %b want 1/0", stall, done); end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || stall !== 1'b0) begin n_mis++; $display("FAIL flush_to_idle: busy %b stall %b want 0/0", busy, stall); end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_mis++; $display("FAIL flush_no_done: got %0d pulses want 0", n_done); end
    n_cmp++; if (hi !== last_hi || lo !== last_lo) begin n_mis++; $display("FAIL flush_hold: got %h/%h want %h/%h", hi, lo, last_hi, last_lo); end

    // Flush and start together in IDLE: flush wins.
    start = 1'b1; flush = 1'b1; op = 1'b1; opa = 32'd9; opb = 32'd2;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_mis++; $display("FAIL flush_start_idle_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL flush_start_idle_busy: got %b want 0", busy); end

    // Flush in DONE: no pulse, but HI/LO were written on entry.
    @(posedge clk); #1;
    exp_r = ref_result(1'b1, 32'd1000, 32'd33);
    start = 1'b1; op = 1'b1; opa = 32'd1000; opb = 32'd33;
    @(posedge clk); #1;
    repeat (33) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_mis++; $display("FAIL flush_done_pulse: done %b busy %b want 0/0", done, busy); end
    n_cmp++; if (hi !== exp_r[63:32] || lo !== exp_r[31:0]) begin n_mis++; $display("FAIL flush_done_result: got %h/%h want %h/%h", hi, lo, exp_r[63:32], exp_r[31:0]); end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_mis++; $display("FAIL flush_done_idle: busy %b done %b want 0/0", busy, done); end
    last_hi = exp_r[63:32]; last_lo = exp_r[31:0];

    // The following DIVU runs normally.
    begin
      int cyc, slo, blo;
      exp_r = ref_result(1'b1, 32'd77, 32'd10);
      run_op(1'b1, 32'd77, 32'd10, cyc, slo, blo);
      n_cmp++; if (cyc !== 33 || hi !== exp_r[63:32] || lo !== exp_r[31:0]) begin n_mis++; $display("FAIL flush_after_divu: cyc %0d got %h/%h want 33 %h/%h", cyc, hi, lo, exp_r[63:32], exp_r[31:0]); end
      start = 1'b0;
      @(posedge clk); #1;
      last_hi = exp_r[63:32]; last_lo = exp_r[31:0];
    end
  endtask

  task automatic test_start_held();
    logic [63:0] exp_r;
    int cyc, slo, blo, n_done, n_busy;
    exp_r = ref_result(1'b0, 32'hDEAD_BEEF, 32'd3);
    run_op(1'b0, 32'hDEAD_BEEF, 32'd3, cyc, slo, blo);
    n_cmp++; if (cyc !== 33 || done !== 1'b1) begin n_mis++; $display("FAIL held_first_done: cyc %0d done %b want 33/1", cyc, done); end
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) n_done++;
      if (busy) n_busy++;
      @(posedge clk); #1;
    end
    n_cmp++; if (n_done !== 0 || n_busy !== 0) begin n_mis++; $display("FAIL held_retrigger: done %0d busy %0d want 0/0", n_done, n_busy); end
    n_cmp++; if (hi !== exp_r[63:32] || lo !== exp_r[31:0]) begin n_mis++; $display("FAIL held_result: got %h/%h want %h/%h", hi, lo, exp_r[63:32], exp_r[31:0]); end
    last_hi = exp_r[63:32]; last_lo = exp_r[31:0];
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_a, exp_b;
    int cyc, slo, blo;
    exp_a = ref_result(1'b0, 32'h0001_0001, 32'h0002_0003);
    exp_b = ref_result(1'b1, 32'hCAFE_F00D, 32'd1234);
    run_op(1'b0, 32'h0001_0001, 32'h0002_0003, cyc, slo, blo);
    n_cmp++; if (cyc !== 33 || lo !== exp_a[31:0] || hi !== exp_a[63:32]) begin n_mis++; $display("FAIL b2b_first: cyc %0d got %h/%h want 33 %h/%h", cyc, hi, lo, exp_a[63:32], exp_a[31:0]); end
    @(posedge clk); #1;
    run_op(1'b1, 32'hCAFE_F00D, 32'd1234, cyc, slo, blo);
    n_cmp++; if (cyc !== 33 || slo !== 0) begin n_mis++; $display("FAIL b2b_second_timing: cyc %0d stall low %0d want 33/0", cyc, slo); end
    n_cmp++; if (lo !== exp_b[31:0] || hi !== exp_b[63:32]) begin n_mis++; $display("FAIL b2b_second: got %h/%h want %h/%h", hi, lo, exp_b[63:32], exp_b[31:0]); end
    start = 1'b0;
    @(posedge clk); #1;
    last_hi = exp_b[63:32]; last_lo = exp_b[31:0];
  endtask

  task automatic test_reset_mid_run();
    int cyc, slo, blo;
    start = 1'b1; op = 1'b0; opa = 32'hFFFF_0000; opb = 32'h0000_FFFF; flush = 1'b0;
    @(posedge clk); #1;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0; start = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0 || busy !== 1'b0) begin n_mis++; $display("FAIL rst_mid_outputs: stall %b busy %b want 0/0", stall, busy); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_mis++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", hi, lo); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_mid_hold: busy %b want 0", busy); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 32'd2, 32'd2, cyc, slo, blo);
    n_cmp++; if (cyc !== 33 || lo !== 32'd4 || hi !== 32'd0) begin n_mis++; $display("FAIL rst_mid_after: cyc %0d got %h/%h want 33 0/4", cyc, hi, lo); end
    start = 1'b0;
    @(posedge clk); #1;
    last_hi = 32'd0; last_lo = 32'd4;
  endtask

  task automatic test_random();
    logic [63:0] exp_r;
    logic        o;
    logic [31:0] a, b;
    int cyc, slo, blo, bad;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(1, 0));
      a = $urandom;
      case ($urandom_range(3, 0))
        0:       b = 32'd0;
        1:       b = $urandom_range(15, 1);
        default: b = $urandom;
      endcase
      exp_r = ref_result(o, a, b);
      run_op(o, a, b, cyc, slo, blo);
      n_cmp++;
      if (cyc !== 33 || slo !== 0 || hi !== exp_r[63:32] || lo !== exp_r[31:0]) begin
        n_mis++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: cyc %0d got %h/%h want 33 %h/%h", i, o, a, b, cyc, hi, lo, exp_r[63:32], exp_r[31:0]);
      end
      start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_mulu();
    test_divu();
    test_flush();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
